// File: rtl/sw_seq_feeder_pkg.sv
// Shared definitions for the Smith-Waterman sequence feeder: base and state
// encodings, word packing and default sequence lengths shared with the sw core.
package sw_seq_feeder_pkg;

  localparam int unsigned BASES_PER_WORD = 16;
  localparam int unsigned SCORE_W        = 12;
  localparam int unsigned DEFAULT_S_LEN  = 256;
  localparam int unsigned DEFAULT_T_LEN  = 128;

  typedef enum logic [1:0] {
    BaseA = 2'd0,
    BaseC = 2'd1,
    BaseG = 2'd2,
    BaseT = 2'd3
  } base_e;

  typedef enum logic [2:0] {
    StLoad,
    StClear,
    StStream,
    StWait,
    StResult
  } state_e;

  function automatic int unsigned words_of(input int unsigned bases);
    return bases / BASES_PER_WORD;
  endfunction

endpackage

// File: rtl/sw_seq_feeder_if.sv
// Host/core-facing signal bundle of the sequence feeder. The slave modport is the
// feeder itself; the master modport is the host plus the sw core around it.
interface sw_seq_feeder_if;

  logic                                   in_valid;
  logic                                   in_ready;
  logic [31:0]                            in_data;
  logic                                   sw_rst;
  logic                                   sw_valid;
  logic [1:0]                             sw_data_s;
  logic [1:0]                             sw_data_t;
  logic                                   sw_finish;
  logic [sw_seq_feeder_pkg::SCORE_W-1:0]  sw_max;
  logic                                   res_valid;
  logic                                   res_ready;
  logic [sw_seq_feeder_pkg::SCORE_W-1:0]  res_max;
  logic                                   res_err;
  logic                                   busy;

  modport master (
    output in_valid, in_data, sw_finish, sw_max, res_ready,
    input  in_ready, sw_rst, sw_valid, sw_data_s, sw_data_t, res_valid, res_max, res_err, busy
  );

  modport slave (
    input  in_valid, in_data, sw_finish, sw_max, res_ready,
    output in_ready, sw_rst, sw_valid, sw_data_s, sw_data_t, res_valid, res_max, res_err, busy
  );

endinterface

// File: rtl/sw_seq_feeder_seq_buffer.sv
// DEPTH x 2-bit base store with a 16-base word write port and a single-base
// asynchronous read port. DEPTH must be a multiple of 16 and at least 32.
module sw_seq_feeder_seq_buffer
  import sw_seq_feeder_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_S_LEN,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned BW   = $clog2(BASES_PER_WORD),
  localparam int unsigned WAW  = AW - BW
) (
  input  logic           clk,
  input  logic           we,
  input  logic [WAW-1:0] waddr,
  input  logic [31:0]    wdata,
  input  logic [AW-1:0]  raddr,
  output logic [1:0]     rdata
);

  logic [1:0] mem [DEPTH];
  logic [BASES_PER_WORD-1:0][1:0] wbases;

  assign wbases = wdata;

  // Contents survive reset; a new job always overwrites every entry.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < BASES_PER_WORD; i++) begin
        mem[{waddr, BW'(i)}] <= wbases[BW'(i)];
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sw_seq_feeder.sv
// Loads S/T sequences, resets and streams them into the sw core, then returns its score.
// Define SW_SEQ_FEEDER_TIMEOUT_EN to add a WAIT watchdog that reports res_err.
module sw_seq_feeder
  import sw_seq_feeder_pkg::*;
#(
  parameter int unsigned S_LEN = DEFAULT_S_LEN,
  parameter int unsigned T_LEN = DEFAULT_T_LEN
`ifdef SW_SEQ_FEEDER_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT = 1024
`endif
) (
  input logic              clk,
  input logic              reset,
  sw_seq_feeder_if.slave   bus
);

  localparam int unsigned S_WORDS = words_of(S_LEN);
  localparam int unsigned T_WORDS = words_of(T_LEN);
  localparam int unsigned N_WORDS = S_WORDS + T_WORDS;
  localparam int unsigned SAW     = $clog2(S_LEN);
  localparam int unsigned TAW     = $clog2(T_LEN);
  localparam int unsigned BW      = $clog2(BASES_PER_WORD);
  localparam int unsigned SWAW    = SAW - BW;
  localparam int unsigned TWAW    = TAW - BW;
  localparam int unsigned WCW     = $clog2(N_WORDS);

  localparam logic [WCW-1:0] WORD_LAST = WCW'(N_WORDS - 1);
  localparam logic [WCW-1:0] S_WORDS_W = WCW'(S_WORDS);
  localparam logic [SAW-1:0] BASE_LAST = SAW'(S_LEN - 1);
  localparam logic [SAW-1:0] T_END     = SAW'(T_LEN % S_LEN);
  localparam bit             T_FULL    = (T_LEN == S_LEN);

  state_e           state_q, state_d;
  logic [WCW-1:0]   word_q, word_d;
  logic [SAW-1:0]   base_q, base_d;
  logic             capture;
  logic             s_we, t_we, t_active;
  logic [TWAW-1:0]  t_waddr;
  logic [1:0]       s_rdata, t_rdata;

`ifdef SW_SEQ_FEEDER_TIMEOUT_EN
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);
  logic [15:0] wd_q, wd_d;
  logic        timeout;
`endif

  logic               in_ready_q, in_ready_d;
  logic               sw_rst_q, sw_rst_d;
  logic               sw_valid_q, sw_valid_d;
  logic [1:0]         sw_data_s_q, sw_data_s_d;
  logic [1:0]         sw_data_t_q, sw_data_t_d;
  logic               res_valid_q, res_valid_d;
  logic [SCORE_W-1:0] res_max_q, res_max_d;
  logic               res_err_q, res_err_d;
  logic               busy_q, busy_d;

  assign t_waddr = TWAW'(word_q - S_WORDS_W);

  sw_seq_feeder_seq_buffer #(
    .DEPTH (S_LEN)
  ) u_s_buf (
    .clk   (clk),
    .we    (s_we),
    .waddr (word_q[SWAW-1:0]),
    .wdata (bus.in_data),
    .raddr (base_d),
    .rdata (s_rdata)
  );

  sw_seq_feeder_seq_buffer #(
    .DEPTH (T_LEN)
  ) u_t_buf (
    .clk   (clk),
    .we    (t_we),
    .waddr (t_waddr),
    .wdata (bus.in_data),
    .raddr (base_d[TAW-1:0]),
    .rdata (t_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StLoad;
      word_q      <= '0;
      base_q      <= '0;
`ifdef SW_SEQ_FEEDER_TIMEOUT_EN
      wd_q        <= '0;
`endif
      in_ready_q  <= 1'b0;
      sw_rst_q    <= 1'b1;
      sw_valid_q  <= 1'b0;
      sw_data_s_q <= '0;
      sw_data_t_q <= '0;
      res_valid_q <= 1'b0;
      res_max_q   <= '0;
      res_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      base_q      <= base_d;
`ifdef SW_SEQ_FEEDER_TIMEOUT_EN
      wd_q        <= wd_d;
`endif
      in_ready_q  <= in_ready_d;
      sw_rst_q    <= sw_rst_d;
      sw_valid_q  <= sw_valid_d;
      sw_data_s_q <= sw_data_s_d;
      sw_data_t_q <= sw_data_t_d;
      res_valid_q <= res_valid_d;
      res_max_q   <= res_max_d;
      res_err_q   <= res_err_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    base_d  = base_q;
    s_we    = 1'b0;
    t_we    = 1'b0;
    capture = 1'b0;
`ifdef SW_SEQ_FEEDER_TIMEOUT_EN
    wd_d    = wd_q;
    timeout = 1'b0;
`endif
    unique case (state_q)
      StLoad: begin
        if (bus.in_valid && in_ready_q) begin
          if (word_q < S_WORDS_W) s_we = 1'b1;
          else                    t_we = 1'b1;
          if (word_q == WORD_LAST) begin
            word_d  = '0;
            state_d = StClear;
          end else begin
            word_d = word_q + 1'b1;
          end
        end
      end
      StClear: begin
        base_d  = '0;
        state_d = StStream;
      end
      StStream: begin
`ifdef SW_SEQ_FEEDER_TIMEOUT_EN
        wd_d = '0;
`endif
        if (base_q == BASE_LAST) begin
          base_d  = '0;
          state_d = StWait;
        end else begin
          base_d = base_q + 1'b1;
        end
      end
      StWait: begin
        // A finish seen on the watchdog's last cycle still counts as a normal result.
        if (bus.sw_finish) begin
          capture = 1'b1;
          state_d = StResult;
        end
`ifdef SW_SEQ_FEEDER_TIMEOUT_EN
        else if (wd_q == WD_LAST) begin
          timeout = 1'b1;
          state_d = StResult;
        end else begin
          wd_d = wd_q + 16'd1;
        end
`endif
      end
      StResult: begin
        if (bus.res_ready) begin
          word_d  = '0;
          base_d  = '0;
          state_d = StLoad;
        end
      end
      default: state_d = StLoad;
    endcase
  end

  // Outputs are decoded from the next state so each register matches the state it enters.
  always_comb begin
    t_active    = T_FULL || (base_d < T_END);
    in_ready_d  = (state_d == StLoad);
    sw_rst_d    = (state_d == StClear);
    sw_valid_d  = (state_d == StStream);
    sw_data_s_d = '0;
    sw_data_t_d = '0;
    if (sw_valid_d) begin
      sw_data_s_d = s_rdata;
      if (t_active) sw_data_t_d = t_rdata;
    end
    res_valid_d = (state_d == StResult);
    res_max_d   = res_max_q;
    if (capture) res_max_d = bus.sw_max;
`ifdef SW_SEQ_FEEDER_TIMEOUT_EN
    res_err_d = res_err_q;
    if (capture) res_err_d = 1'b0;
    if (timeout) begin
      res_max_d = '1;
      res_err_d = 1'b1;
    end
`else
    res_err_d = 1'b0;
`endif
    busy_d = (state_d != StLoad);
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.sw_rst    = sw_rst_q;
  assign bus.sw_valid  = sw_valid_q;
  assign bus.sw_data_s = sw_data_s_q;
  assign bus.sw_data_t = sw_data_t_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_max   = res_max_q;
  assign bus.res_err   = res_err_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_sw_seq_feeder.sv
// Scoreboard bench for sw_seq_feeder: jobs push expected stream beats and results into
// queues that a negedge monitor pops. Honours SW_SEQ_FEEDER_TIMEOUT_EN.
module tb_sw_seq_feeder;
  import sw_seq_feeder_pkg::*;

  localparam int unsigned S_LEN   = 256;
  localparam int unsigned T_LEN   = 128;
  localparam int unsigned S_WORDS = S_LEN / 16;
  localparam int unsigned NW      = (S_LEN + T_LEN) / 16;
`ifdef SW_SEQ_FEEDER_TIMEOUT_EN
  localparam int unsigned TIMEOUT   = 50;
  localparam int unsigned FIN_DELAY = TIMEOUT - 1;
`else
  localparam int unsigned FIN_DELAY = 400;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;

  sw_seq_feeder_if bus ();

  sw_seq_feeder #(
    .S_LEN   (S_LEN),
    .T_LEN   (T_LEN)
`ifdef SW_SEQ_FEEDER_TIMEOUT_EN
    ,
    .TIMEOUT (TIMEOUT)
`endif
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] s;
    logic [1:0] t;
  } beat_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [1:0]  s_seq [S_LEN];
  logic [1:0]  t_seq [T_LEN];
  beat_t       exp_beats [$];
  logic [11:0] exp_max [$];
  logic        exp_err [$];
  int          hs_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic gen_job(input bit pattern);
    beat_t b;
    for (int k = 0; k < int'(S_LEN); k++)
      s_seq[k] = pattern ? 2'(k % 4) : 2'($urandom_range(0, 3));
    for (int k = 0; k < int'(T_LEN); k++)
      t_seq[k] = pattern ? 2'd2 : 2'($urandom_range(0, 3));
    for (int k = 0; k < int'(S_LEN); k++) begin
      b.s = s_seq[k];
      b.t = 2'd0;
      if (k < int'(T_LEN)) b.t = t_seq[k];
      exp_beats.push_back(b);
    end
  endtask

  function automatic logic [31:0] word_at(input int idx);
    logic [31:0] w;
    w = '0;
    for (int b = 0; b < 16; b++) begin
      if (idx < int'(S_WORDS)) w[2*b +: 2] = s_seq[idx*16 + b];
      else                     w[2*b +: 2] = t_seq[(idx - int'(S_WORDS))*16 + b];
    end
    return w;
  endfunction

  // Returns at the negedge of STREAM cycle 0.
  task automatic load_job(input bit drop, output bit ok);
    int  idx = 0;
    int  guard = 0;
    bit  hs;
    while (idx < int'(NW) && guard < 4000) begin
      @(negedge clk);
      bus.in_valid = drop ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.in_data  = word_at(idx);
      hs = bus.in_valid && bus.in_ready;
      @(posedge clk);
      if (hs) idx++;
      guard++;
    end
    ok = (idx == int'(NW));
    check("load_complete", 32'(idx), 32'(NW));
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.sw_finish = 1'b0;
    check("clear_sw_rst", 32'(bus.sw_rst), 32'd1);
    check("clear_sw_valid", 32'(bus.sw_valid), 32'd0);
    check("clear_in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    check("first_sw_valid", 32'(bus.sw_valid), 32'd1);
    check("stream_sw_rst", 32'(bus.sw_rst), 32'd0);
  endtask

  task automatic run_job(input bit pattern, input bit drop, input logic [11:0] mx,
                         input int abort_at, input bit timeout_job, input int hold);
    bit ok;
    int n;
    gen_job(pattern);
    load_job(drop, ok);
    if (!ok) return;
    if (abort_at >= 0) begin
      repeat (abort_at) @(negedge clk);
      #2 reset = 1'b1;
      exp_beats.delete();
      #1;
      check("abort_sw_valid", 32'(bus.sw_valid), 32'd0);
      check("abort_sw_rst", 32'(bus.sw_rst), 32'd1);
      check("abort_busy", 32'(bus.busy), 32'd0);
      repeat (2) @(negedge clk);
      #2 reset = 1'b0;
      @(negedge clk);
      check("abort_in_ready", 32'(bus.in_ready), 32'd1);
      check("abort_idle_rst", 32'(bus.sw_rst), 32'd0);
      return;
    end
    n = 0;
    while (bus.sw_valid && n < int'(S_LEN) + 20) begin
      @(negedge clk);
      n++;
    end
    check("stream_ended", 32'(bus.sw_valid), 32'd0);
    if (!timeout_job) begin
      repeat (FIN_DELAY) @(negedge clk);
      check("res_before_finish", 32'(bus.res_valid), 32'd0);
      bus.sw_finish = 1'b1;
      bus.sw_max    = mx;
      exp_max.push_back(mx);
      exp_err.push_back(1'b0);
      @(negedge clk);
      check("res_latency", 32'(bus.res_valid), 32'd1);
    end else begin
`ifdef SW_SEQ_FEEDER_TIMEOUT_EN
      exp_max.push_back(12'hFFF);
      exp_err.push_back(1'b1);
      n = 0;
      while (!bus.res_valid && n < int'(TIMEOUT) + 10) begin
        @(negedge clk);
        n++;
      end
      check("timeout_cycles", 32'(n), 32'(TIMEOUT));
`endif
    end
    repeat (hold) begin
      bus.sw_finish = 1'($urandom);
      bus.sw_max    = 12'($urandom);
      @(negedge clk);
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    bus.sw_finish = 1'b1;
    check("res_released", 32'(bus.res_valid), 32'd0);
    check("back_in_load", 32'(bus.in_ready), 32'd1);
  endtask

  always @(posedge clk) begin
    if (!reset && bus.in_valid && bus.in_ready) hs_total++;
  end

  // Monitor: all comparisons against queued expectations happen here.
  int          beat_cnt = 0;
  int          rst_run = 0;
  int          hs_mark = 0;
  bit          prev_valid = 1'b0;
  bit          prev_res = 1'b0;
  logic [11:0] held_max;
  logic        held_err;
  beat_t       mb;

  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        beat_cnt   = 0;
        rst_run    = 0;
        prev_valid = 1'b0;
        prev_res   = 1'b0;
        hs_mark    = hs_total;
      end else begin
        if (bus.sw_rst && bus.busy) begin
          rst_run++;
          if (rst_run == 1) begin
            check("word_handshakes", 32'(hs_total - hs_mark), 32'(NW));
            hs_mark = hs_total;
          end
        end else if (rst_run != 0) begin
          check("rst_pulse_len", 32'(rst_run), 32'd1);
          rst_run = 0;
        end
        if (bus.sw_valid) begin
          if (exp_beats.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL stream_extra: unexpected beat s=%0d t=%0d", bus.sw_data_s,
                     bus.sw_data_t);
          end else begin
            mb = exp_beats.pop_front();
            check("stream_s", 32'(bus.sw_data_s), 32'(mb.s));
            check("stream_t", 32'(bus.sw_data_t), 32'(mb.t));
          end
          beat_cnt++;
        end else if (prev_valid) begin
          check("stream_len", 32'(beat_cnt), 32'(S_LEN));
          check("idle_data", 32'({bus.sw_data_s, bus.sw_data_t}), 32'd0);
          beat_cnt = 0;
        end
        prev_valid = bus.sw_valid;
        if (bus.res_valid) begin
          if (!prev_res) begin
            if (exp_max.size() == 0) begin
              n_tests++;
              n_fail++;
              $display("FAIL res_extra: unexpected result 0x%0h", bus.res_max);
              held_max = bus.res_max;
              held_err = bus.res_err;
            end else begin
              held_max = exp_max.pop_front();
              held_err = exp_err.pop_front();
              check("res_max", 32'(bus.res_max), 32'(held_max));
              check("res_err", 32'(bus.res_err), 32'(held_err));
            end
          end else begin
            check("res_max_hold", 32'(bus.res_max), 32'(held_max));
            check("res_err_hold", 32'(bus.res_err), 32'(held_err));
          end
        end
        prev_res = bus.res_valid;
      end
    end
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.sw_finish = 1'b0;
    bus.sw_max    = '0;
    bus.res_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_sw_rst", 32'(bus.sw_rst), 32'd1);
    check("rst_sw_valid", 32'(bus.sw_valid), 32'd0);
    check("rst_res_valid", 32'(bus.res_valid), 32'd0);
    check("rst_res_max", 32'(bus.res_max), 32'd0);
    check("rst_res_err", 32'(bus.res_err), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    #2 reset = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("post_rst_sw_rst", 32'(bus.sw_rst), 32'd0);

    run_job(1'b1, 1'b0, 12'h123, -1, 1'b0, 10);
    run_job(1'b0, 1'b1, 12'($urandom), -1, 1'b0, int'($urandom_range(0, 3)));
    run_job(1'b0, 1'b1, 12'h000, 100, 1'b0, 0);
    run_job(1'b0, 1'b1, 12'($urandom), -1, 1'b0, int'($urandom_range(0, 3)));
`ifdef SW_SEQ_FEEDER_TIMEOUT_EN
    run_job(1'b0, 1'b0, 12'h000, -1, 1'b1, 2);
`endif
    @(negedge clk);
    check("beats_left", 32'(exp_beats.size()), 32'd0);
    check("results_left", 32'(exp_max.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete, %0d failed so far", n_fail);
    $fatal(1, "time limit");
  end

endmodule
